// File: rtl/c880_bist_ctrl_if.sv
// c880_bist_ctrl_if
// Bundles the signals that pass between the c880 BIST controller and the
// benchmark harness. The harness (the master) issues start, returns the c880
// responses on rsp_in and supplies the golden signature. The controller (the
// slave) drives the stimulus bus and reports status and signature.
//   start      harness -> ctrl  run request
//   pat_out    ctrl -> harness  60-bit stimulus for c880 inputs N1..N268
//   rsp_in     harness -> ctrl  26-bit c880 outputs N388..N880
//   golden     harness -> ctrl  expected signature
//   busy/done  ctrl -> harness  run status
//   signature  ctrl -> harness  MISR contents
//   pass       ctrl -> harness  done && signature == golden
//   rsp_mask   harness -> ctrl  X-mask; exists only with C880_BIST_XMASK_EN
interface c880_bist_ctrl_if;
    logic        start;
    logic [59:0] pat_out;
    logic [25:0] rsp_in;
    logic [25:0] golden;
    logic        busy;
    logic        done;
    logic [25:0] signature;
    logic        pass;
`ifdef C880_BIST_XMASK_EN
    logic [25:0] rsp_mask;
`endif

    modport master (
`ifdef C880_BIST_XMASK_EN
        output rsp_mask,
`endif
        output start, rsp_in, golden,
        input  pat_out, busy, done, signature, pass
    );

    modport slave (
`ifdef C880_BIST_XMASK_EN
        input  rsp_mask,
`endif
        input  start, rsp_in, golden,
        output pat_out, busy, done, signature, pass
    );
endinterface

// File: rtl/c880_bist_ctrl.sv
// c880_bist_ctrl
// BIST controller for the c880 netlist: a 60-bit LFSR (x^60+x^59+1) produces
// NPAT patterns per run, and a 26-bit MISR (x^26+x^6+x^2+x+1) compacts the
// responses, which arrive LAT cycles after their pattern. At the end of a run
// the signature is frozen and compared against golden.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  c880_bist_ctrl_if.slave (start, pat_out, rsp_in, golden, busy,
//        done, signature, pass, and rsp_mask when masking is enabled)
// Optional feature: define C880_BIST_XMASK_EN to add rsp_mask; the MISR
// then absorbs rsp_in & ~rsp_mask.
module c880_bist_ctrl #(
    parameter int unsigned NPAT = 1024,
    parameter int unsigned LAT  = 0,
    parameter logic [59:0] SEED = 60'h1
) (
    input logic            clk,
    input logic            rst,
    c880_bist_ctrl_if.slave bus
);
    localparam logic [59:0] SEED_EFF = (SEED == '0) ? 60'h1 : SEED;
    localparam logic [15:0] LAST_CNT = 16'(NPAT - 1);
    localparam logic [1:0]  LAST_DRN = 2'((LAT > 0) ? LAT - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [59:0] pat_q, pat_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  drn_q, drn_d;
    logic [25:0] sig_q, sig_d;
    logic [25:0] rsp_eff;
    logic        in_run;
    logic        cap_en;
    logic        fb;

    assign in_run = (state_q == RUN);

    // The capture enable is the RUN flag delayed by LAT cycles, so the MISR
    // sees exactly the NPAT responses belonging to this run's patterns.
    generate
        if (LAT == 0) begin : g_nolat
            assign cap_en = in_run;
        end else begin : g_lat
            logic [LAT-1:0] vld_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_q <= '0;
                else     vld_q <= LAT'({vld_q, in_run});
            end
            assign cap_en = vld_q[LAT-1];
        end
    endgenerate

`ifdef C880_BIST_XMASK_EN
    assign rsp_eff = bus.rsp_in & ~bus.rsp_mask;
`else
    assign rsp_eff = bus.rsp_in;
`endif

    assign fb = sig_q[25] ^ sig_q[5] ^ sig_q[1] ^ sig_q[0];

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        sig_d   = sig_q;
        if (cap_en) sig_d = {sig_q[24:0], fb} ^ rsp_eff;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pat_d   = SEED_EFF;
                    sig_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q != LAST_CNT) begin
                    pat_d = {pat_q[58:0], pat_q[59] ^ pat_q[58]};
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    drn_d   = '0;
                    state_d = (LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drn_q == LAST_DRN) state_d = DONE;
                else                   drn_d   = drn_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            drn_q   <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            sig_q   <= sig_d;
        end
    end

    assign bus.pat_out   = pat_q;
    assign bus.signature = sig_q;
    assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = (state_q == DONE) && (sig_q == bus.golden);
endmodule

// File: tb/tb_c880_bist_ctrl.sv
// tb_c880_bist_ctrl
// Scoreboard bench for c880_bist_ctrl. Three instances cover LAT=0, LAT=2
// with SEED=0 and the single-pattern case. Runs are issued one at a time; the
// expected pattern stream and end-of-run result are queued at issue and a
// negedge monitor pops them as the DUTs present busy/done.
// Honours C880_BIST_XMASK_EN for the rsp_mask port.
`timescale 1ns/1ps
module tb_c880_bist_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    c880_bist_ctrl_if ifa ();
    c880_bist_ctrl_if ifb ();
    c880_bist_ctrl_if ifc ();

    c880_bist_ctrl #(.NPAT(4), .LAT(0), .SEED(60'h1))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    c880_bist_ctrl #(.NPAT(3), .LAT(2), .SEED(60'h0))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    c880_bist_ctrl #(.NPAT(1), .LAT(1), .SEED(60'h0F0F123456789AB))
        u_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct packed {
        logic [59:0] pat;
        logic        busy;
        logic        done;
        logic [25:0] sig;
        logic        pass;
    } obs_t;

    typedef struct {
        logic [25:0] sig;
        logic        pass;
        int unsigned tdone;
    } res_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    bit          mon_en = 1'b0;
    logic [59:0] patq[$];
    res_t        resq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: LFSR x^60+x^59+1 and MISR x^26+x^6+x^2+x+1 written
    // as shift-plus-tap-parity.
    localparam logic [59:0] LTAP = 60'hC00000000000000;
    localparam logic [25:0] MTAP = 26'h2000023;

    function automatic logic [59:0] lfsr_nx(logic [59:0] p);
        return {p[58:0], ^(p & LTAP)};
    endfunction

    function automatic logic [25:0] misr_nx(logic [25:0] m, logic [25:0] r);
        return {m[24:0], ^(m & MTAP)} ^ r;
    endfunction

    function automatic int np_of(int d);
        return (d == 0) ? 4 : (d == 1) ? 3 : 1;
    endfunction

    function automatic int lat_of(int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 1;
    endfunction

    // Instance b uses SEED=0, which the controller replaces with 1.
    function automatic logic [59:0] seed_of(int d);
        return (d == 2) ? 60'h0F0F123456789AB : 60'h1;
    endfunction

    function automatic obs_t obs(int d);
        case (d)
            0:       return {ifa.pat_out, ifa.busy, ifa.done, ifa.signature, ifa.pass};
            1:       return {ifb.pat_out, ifb.busy, ifb.done, ifb.signature, ifb.pass};
            default: return {ifc.pat_out, ifc.busy, ifc.done, ifc.signature, ifc.pass};
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected DUT activity (t=%0t)", name, $time);
    endtask

    task automatic drv(int d, logic s, logic [25:0] r, logic [25:0] m);
        case (d)
            0: begin
                ifa.start = s; ifa.rsp_in = r;
`ifdef C880_BIST_XMASK_EN
                ifa.rsp_mask = m;
`endif
            end
            1: begin
                ifb.start = s; ifb.rsp_in = r;
`ifdef C880_BIST_XMASK_EN
                ifb.rsp_mask = m;
`endif
            end
            default: begin
                ifc.start = s; ifc.rsp_in = r;
`ifdef C880_BIST_XMASK_EN
                ifc.rsp_mask = m;
`endif
            end
        endcase
    endtask

    task automatic set_gold(int d, logic [25:0] g);
        case (d)
            0:       ifa.golden = g;
            1:       ifb.golden = g;
            default: ifc.golden = g;
        endcase
    endtask

    // rmode: 0 random, 1 all-zero, 2 constant 1, 3 all-ones fully masked.
    // nruns > 1 holds start high so each run restarts straight from DONE.
    task automatic run(int d, int nruns, int rmode, bit gmatch, bit mid_start);
        int          np;
        int          lt;
        int unsigned t0;
        logic [59:0] p;
        logic [25:0] sig;
        logic [25:0] x;
        logic [25:0] g;
        logic [25:0] rs[$];
        logic [25:0] ms[$];
        bit          last;
        res_t        e;
        np = np_of(d);
        lt = lat_of(d);
        drv(d, 1'b1, 26'($urandom()), 26'($urandom()));
        @(posedge clk); #1;
        for (int k = 0; k < nruns; k++) begin
            t0   = cyc;
            last = (k == nruns - 1);
            p    = seed_of(d);
            for (int i = 0; i < np + lt; i++) begin
                patq.push_back(p);
                if (i < np - 1) p = lfsr_nx(p);
            end
            rs.delete();
            ms.delete();
            sig = '0;
            for (int i = 0; i < np; i++) begin
                case (rmode)
                    1:       begin rs.push_back('0);                  ms.push_back('0); end
                    2:       begin rs.push_back(26'h1);               ms.push_back('0); end
                    3:       begin rs.push_back('1);                  ms.push_back('1); end
                    default: begin rs.push_back(26'($urandom()));     ms.push_back(26'($urandom())); end
                endcase
`ifdef C880_BIST_XMASK_EN
                sig = misr_nx(sig, rs[i] & ~ms[i]);
`else
                sig = misr_nx(sig, rs[i]);
`endif
            end
            x = 26'($urandom());
            if (x == '0) x = 26'h5;
            g = gmatch ? sig : (sig ^ x);
            set_gold(d, g);
            e.sig   = sig;
            e.pass  = (g == sig);
            e.tdone = t0 + np + lt;
            resq.push_back(e);
            for (int c = 0; c < np + lt; c++) begin
                if (c >= lt)
                    drv(d, last ? (mid_start && c == 1) : 1'b1, rs[c-lt], ms[c-lt]);
                else
                    drv(d, last ? (mid_start && c == 1) : 1'b1, 26'($urandom()), '0);
                @(posedge clk); #1;
            end
            // DONE cycle: junk response must not be absorbed.
            drv(d, last ? 1'b0 : 1'b1, 26'($urandom()), '0);
            @(posedge clk); #1;
        end
        drv(d, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pattern stream on every busy cycle, result on each done rise.
    bit [2:0] busy_p;
    bit [2:0] done_p;
    always @(negedge clk) begin
        obs_t o;
        res_t e;
        if (rst || !mon_en) begin
            busy_p = '0;
            done_p = '0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                o = obs(d);
                if (o.busy) begin
                    if (!busy_p[d]) chk("sig_clr", 64'(o.sig), 64'h0);
                    chk("pass_busy", 64'(o.pass), 64'h0);
                    if (patq.size() == 0) fail("busy_extra");
                    else chk("pat", 64'(o.pat), 64'(patq.pop_front()));
                end
                if (o.done && !done_p[d]) begin
                    if (resq.size() == 0) fail("done_extra");
                    else begin
                        e = resq.pop_front();
                        chk("sig", 64'(o.sig), 64'(e.sig));
                        chk("pass", 64'(o.pass), 64'(e.pass));
                        chk("done_cyc", 64'(cyc), 64'(e.tdone));
                        chk("busy_len", 64'(patq.size()), 64'h0);
                    end
                end
                busy_p[d] = o.busy;
                done_p[d] = o.done;
            end
        end
    end

    initial begin
        obs_t o;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            drv(d, 1'b0, '0, '0);
            set_gold(d, '0);
        end
        #1;
        for (int d = 0; d < 3; d++) chk("rst_init", 64'(obs(d)), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        run(0, 1, 1, 1'b1, 1'b0);
        chk("a_zero_sig", 64'(ifa.signature), 64'h0);
        run(1, 1, 2, 1'b1, 1'b0);
        chk("b_const_sig", 64'(ifb.signature), 64'h4);
        run(1, 1, 2, 1'b0, 1'b0);
        run(0, 1, 2, 1'b1, 1'b1);
        run(2, 1, 0, 1'b1, 1'b0);
        run(0, 3, 0, 1'b1, 1'b0);
        run(1, 3, 0, 1'b0, 1'b0);
        run(2, 3, 0, 1'b1, 1'b1);
`ifdef C880_BIST_XMASK_EN
        run(0, 1, 3, 1'b1, 1'b0);
        chk("mask_sig", 64'(ifa.signature), 64'h0);
`endif
        for (int i = 0; i < 12; i++)
            run(int'($urandom_range(0, 2)), int'($urandom_range(1, 2)), 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of a run on instance a.
        mon_en = 1'b0;
        drv(0, 1'b1, 26'h2AAAAAA, '0);
        @(posedge clk); #1;
        drv(0, 1'b0, 26'h2AAAAAA, '0);
        chk("pre_rst_pat", 64'(ifa.pat_out), 64'h1);
        @(posedge clk); #1;
        chk("pre_rst_sig", 64'(ifa.signature), 64'h2AAAAAA);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk("rst_async", 64'(obs(d)), 64'h0);
        @(posedge clk); #1 rst = 1'b0;
        drv(0, 1'b0, '0, '0);
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                o = obs(d);
                chk("idle_busy", 64'(o.busy), 64'h0);
                chk("idle_done", 64'(o.done), 64'h0);
            end
        end
        patq.delete();
        resq.delete();
        @(posedge clk); #1;
        mon_en = 1'b1;
        run(1, 2, 0, 1'b1, 1'b0);
        run(0, 1, 0, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        chk("resq_empty", 64'(resq.size()), 64'h0);
        chk("patq_empty", 64'(patq.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
